// File: rtl/risc8_mem_arbiter_pkg.sv
// risc8_mem_arbiter_pkg: shared state encoding, address defaults and byte order for the memory arbiter
package risc8_mem_arbiter_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam logic [15:0] DMEM_BASE_DEF = 16'hFF00;
  localparam bit BIG_ENDIAN = 1'b1;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    F_HI   = 3'd1,
    F_LO   = 3'd2,
    F_WAIT = 3'd3,
    D_RD   = 3'd4,
    D_RWAIT = 3'd5,
    D_WR   = 3'd6,
    DONE   = 3'd7
  } state_t;
endpackage

// File: rtl/risc8_mem_arbiter_prio.sv
// risc8_mem_arbiter_prio: IDLE grant decision, data first; RISC8_ARB_FAIRNESS_EN adds a data-run limit
module risc8_mem_arbiter_prio #(
  parameter int MAX_DATA_RUN = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic if_req,
  input  logic dm_req,
  input  logic idle,
  output logic grant_if,
  output logic grant_dm
);
`ifdef RISC8_ARB_FAIRNESS_EN
  logic [2:0] cnt;
  logic force_if;
  assign force_if = if_req && cnt == 3'(MAX_DATA_RUN);
  assign grant_if = idle && if_req && (!dm_req || force_if);
  assign grant_dm = idle && dm_req && !force_if;
  // counts data grants that overtook a waiting fetch
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= 3'd0;
    else if (idle) cnt <= (grant_if || !if_req) ? 3'd0 : grant_dm ? cnt + 3'd1 : cnt;
`else
  logic unused_ok;
  assign grant_if = idle && if_req && !dm_req;
  assign grant_dm = idle && dm_req;
  assign unused_ok = &{1'b0, clk, reset_n, MAX_DATA_RUN[0]};
`endif
endmodule

// File: rtl/risc8_mem_arbiter.sv
// risc8_mem_arbiter: shares one byte-wide sync-read RAM between 16-bit fetches and byte data accesses
// Optional fetch fairness guard: define RISC8_ARB_FAIRNESS_EN
module risc8_mem_arbiter
  import risc8_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] DMEM_BASE = ADDR_W'(DMEM_BASE_DEF),
  parameter int MAX_DATA_RUN = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [15:0]       if_instr,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [7:0]        dm_addr,
  input  logic [7:0]        dm_wdata,
  output logic              dm_ready,
  output logic [7:0]        dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);
  state_t state, state_d;
  logic grant_if, grant_dm;
  logic [7:0] hi_q;
  logic [ADDR_W-1:0] mem_addr_d;
  risc8_mem_arbiter_prio #(.MAX_DATA_RUN(MAX_DATA_RUN)) u_prio (
    .clk(clk),
    .reset_n(reset_n),
    .if_req(if_req),
    .dm_req(dm_req),
    .idle(state == IDLE),
    .grant_if(grant_if),
    .grant_dm(grant_dm)
  );
  always_comb begin
    state_d = IDLE;
    case (state)
      IDLE:    state_d = grant_dm ? (dm_we ? D_WR : D_RD) : grant_if ? F_HI : IDLE;
      F_HI:    state_d = F_LO;
      F_LO:    state_d = F_WAIT;
      F_WAIT:  state_d = DONE;
      D_RD:    state_d = D_RWAIT;
      D_RWAIT: state_d = DONE;
      D_WR:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    mem_addr_d = state_d == F_HI ? if_addr
               : state_d == F_LO ? mem_addr + ADDR_W'(1)
               : (state_d == D_RD || state_d == D_WR) ? DMEM_BASE + ADDR_W'(dm_addr)
               : mem_addr;
  end
  // outputs are registered alongside the state; read data lands one cycle after its command
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      hi_q      <= '0;
      if_ready  <= 1'b0;
      if_instr  <= '0;
      dm_ready  <= 1'b0;
      dm_rdata  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_d;
      mem_en    <= state_d inside {F_HI, F_LO, D_RD, D_WR};
      mem_we    <= state_d == D_WR;
      mem_addr  <= mem_addr_d;
      mem_wdata <= state_d == D_WR ? dm_wdata : mem_wdata;
      hi_q      <= state == F_LO ? mem_rdata : hi_q;
      if_ready  <= state == F_WAIT;
      dm_ready  <= state == D_RWAIT || state == D_WR;
      if_instr  <= state == F_WAIT ? (BIG_ENDIAN ? {hi_q, mem_rdata} : {mem_rdata, hi_q}) : if_instr;
      dm_rdata  <= state == D_RWAIT ? mem_rdata : dm_rdata;
    end
endmodule

// File: tb/tb_risc8_mem_arbiter.sv
// tb_risc8_mem_arbiter: directed vector table plus hand sequences for reset, collision, fairness and back-to-back fetch
module tb_risc8_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [15:0] if_addr = '0;
  logic [7:0]  dm_addr = '0, dm_wdata = '0;
  logic        if_ready, dm_ready, mem_en, mem_we;
  logic [15:0] if_instr, mem_addr;
  logic [7:0]  dm_rdata, mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic [7:0]  mem [0:65535];
  int total = 0, bad = 0;

  risc8_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_instr(if_instr),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  kind;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [15:0] exp_data;
    int          exp_lat;
    logic [15:0] exp_a1;
    logic        exp_we1;
    logic [15:0] exp_a2;
  } vec_t;
  vec_t vt[6];

  task automatic txn(input logic [1:0] kind, input logic [15:0] addr, input logic [7:0] wdata,
                     output int lat, output logic [15:0] data, output logic [15:0] a1,
                     output logic we1, output logic en1, output logic [15:0] a2);
    lat = 0; data = '0; a1 = '0; we1 = 1'b0; en1 = 1'b0; a2 = '0;
    @(negedge clk);
    if (kind == 2'd0) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      dm_req = 1'b1; dm_we = kind == 2'd2; dm_addr = addr[7:0]; dm_wdata = wdata;
    end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin a1 = mem_addr; we1 = mem_we; en1 = mem_en; end
      if (i == 2) a2 = mem_addr;
      if (if_ready || dm_ready) begin
        lat = i;
        data = kind == 2'd0 ? if_instr : {8'h00, dm_rdata};
        break;
      end
    end
    if_req = 1'b0; dm_req = 1'b0;
  endtask

  initial begin
    int lat, n, k, dmc, ifc, pulses;
    logic [15:0] data, a1, a2;
    logic we1, en1;
    logic [5:0] seq, seq_exp;
    logic [15:0] b2b_exp [3];
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0010] = 8'h1A; mem[16'h0011] = 8'h2B;
    mem[16'hFFFF] = 8'h5C; mem[16'hFFFE] = 8'h11;
    mem[16'h0000] = 8'hD7; mem[16'h0001] = 8'hE1;
    mem[16'h0002] = 8'hF2; mem[16'h0003] = 8'h03;
    mem[16'h0004] = 8'h44; mem[16'h0005] = 8'h55;
    mem[16'hFF00] = 8'h42;
    vt[0] = '{2'd2, 16'h0005, 8'hC3, 16'h0000, 2, 16'hFF05, 1'b1, 16'h0000};
    vt[1] = '{2'd1, 16'h0005, 8'h00, 16'h00C3, 3, 16'hFF05, 1'b0, 16'h0000};
    vt[2] = '{2'd0, 16'h0010, 8'h00, 16'h1A2B, 4, 16'h0010, 1'b0, 16'h0011};
    vt[3] = '{2'd0, 16'hFFFF, 8'h00, 16'h5CD7, 4, 16'hFFFF, 1'b0, 16'h0000};
    vt[4] = '{2'd2, 16'h00FF, 8'h99, 16'h0000, 2, 16'hFFFF, 1'b1, 16'h0000};
    vt[5] = '{2'd0, 16'hFFFE, 8'h00, 16'h1199, 4, 16'hFFFE, 1'b0, 16'hFFFF};
    b2b_exp[0] = 16'hD7E1; b2b_exp[1] = 16'hF203; b2b_exp[2] = 16'h4455;

    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {if_ready, dm_ready, mem_en, mem_we}, 0);
    chk("rst_data", {if_instr, dm_rdata, mem_wdata}, 0);
    chk("rst_addr", mem_addr, 0);
    reset_n = 1'b1;

    foreach (vt[i]) begin
      txn(vt[i].kind, vt[i].addr, vt[i].wdata, lat, data, a1, we1, en1, a2);
      chk($sformatf("v%0d_lat", i), lat, vt[i].exp_lat);
      chk($sformatf("v%0d_addr1", i), a1, vt[i].exp_a1);
      chk($sformatf("v%0d_we1", i), we1, vt[i].exp_we1);
      chk($sformatf("v%0d_en1", i), en1, 1);
      if (vt[i].kind != 2'd2) chk($sformatf("v%0d_data", i), data, vt[i].exp_data);
      if (vt[i].kind == 2'd0) chk($sformatf("v%0d_addr2", i), a2, vt[i].exp_a2);
    end

    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h0010;
    repeat (2) @(negedge clk);
    chk("rst_flo_addr", mem_addr, 16'h0011);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_ctrl", {if_ready, dm_ready, mem_en, mem_we}, 0);
    chk("rst_mid_data", {if_instr, mem_addr}, 0);
    if_req = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) reset_n = 1'b1;
      if (if_ready) pulses++;
    end
    chk("rst_no_ready", pulses, 0);
    chk("rst_instr_zero", if_instr, 0);
    txn(2'd0, 16'h0010, 8'h00, lat, data, a1, we1, en1, a2);
    chk("rst_refetch_lat", lat, 4);
    chk("rst_refetch_data", data, 16'h1A2B);

    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h0010;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h05;
    dmc = 0; ifc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 4) chk("col_idle_en", mem_en, 0);
      if (i == 5) chk("col_fetch_addr", {mem_en, mem_addr}, {1'b1, 16'h0010});
      if (dm_ready) begin
        dmc = i; dm_req = 1'b0;
        chk("col_rdata", dm_rdata, 8'hC3);
      end
      if (if_ready) begin
        ifc = i; if_req = 1'b0;
        chk("col_instr", if_instr, 16'h1A2B);
        break;
      end
    end
    chk("col_dm_cycle", dmc, 3);
    chk("col_if_cycle", ifc, 8);

    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h0010;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h05;
    n = 0; seq = '0;
    for (int i = 1; i <= 40 && n < 6; i++) begin
      @(negedge clk);
      if (if_ready) begin seq[n] = 1'b1; n++; end
      else if (dm_ready) begin seq[n] = 1'b0; n++; end
    end
    if_req = 1'b0; dm_req = 1'b0;
`ifdef RISC8_ARB_FAIRNESS_EN
    seq_exp = 6'b010000;
`else
    seq_exp = 6'b000000;
`endif
    chk("fair_count", n, 6);
    chk("fair_order", seq, seq_exp);

    repeat (2) @(negedge clk);
    if_req = 1'b1; if_addr = 16'h0000;
    k = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (if_ready) begin
        chk($sformatf("b2b%0d_cycle", k), i, 4 + 5 * k);
        chk($sformatf("b2b%0d_instr", k), if_instr, b2b_exp[k]);
        k++;
        if_addr = 16'(2 * k);
        if (k == 3) begin if_req = 1'b0; break; end
      end
    end
    chk("b2b_pulses", k, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
